seg_frame_decoder: RTL and testbench

Reverse path of the binary-to-segment encoder. Accepts a stream of 8-bit segment codes (bit7..bit0 = a,b,c,d,e,f,g,dp), one per digit position. Decodes each code back to a 4-bit binary value and assembles N_DIGITS values into one frame. The frame is handed downstream with a valid/ready handshake. Used for display loopback checking and for reading segment buses back into the datapath.

---
 rtl/seg_codes_pkg.sv | 21 ++
 rtl/seg_frame_decoder_if.sv | 27 ++
 rtl/seg_pattern_decode.sv | 37 +++
 rtl/seg_frame_decoder.sv | 103 ++++++++++
 tb/tb_seg_frame_decoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_codes_pkg.sv
// Shared seven-segment pattern constants (a..g, MSB = a) and the decoder FSM state type.
// Used by both the segment encoder and seg_frame_decoder.
package seg_codes_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [7:0] SEG_ERR     = 8'b00000001;
  localparam logic [3:0] DIG_INVALID = 4'hF;

  typedef enum logic {COLLECT, HOLD} state_e;

endpackage

// File: rtl/seg_frame_decoder_if.sv
// Handshake bundle for seg_frame_decoder: segment-code input stream and frame output.
// slave = the decoder, master = whatever feeds codes and consumes frames.
interface seg_frame_decoder_if #(
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 8,
  parameter int DIG_W    = 4
) ();
  logic                      seg_valid;
  logic                      seg_ready;
  logic [SEG_W-1:0]          seg_code;
  logic                      frame_start;
  logic                      frame_valid;
  logic                      frame_ready;
  logic [N_DIGITS*DIG_W-1:0] frame_data;
  logic [N_DIGITS-1:0]       frame_err;
  logic [15:0]               err_count;

  modport master (
    output seg_valid, seg_code, frame_start, frame_ready,
    input  seg_ready, frame_valid, frame_data, frame_err, err_count
  );

  modport slave (
    input  seg_valid, seg_code, frame_start, frame_ready,
    output seg_ready, frame_valid, frame_data, frame_err, err_count
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern decoder: a..g matched exactly against the digit table,
// dp ignored; anything else yields DIG_INVALID with err_o set.
module seg_pattern_decode
  import seg_codes_pkg::*;
#(
  parameter int SEG_W = 8,
  parameter int DIG_W = 4
) (
  input  logic [SEG_W-1:0] seg_code_i,
  output logic [DIG_W-1:0] value_o,
  output logic             err_o
);
  logic [3:0] val;
  logic       unused_dp;

  assign unused_dp = seg_code_i[0];

  always_comb begin
    val   = DIG_INVALID;
    err_o = 1'b0;
    case (seg_code_i[SEG_W-1:1])
      SEG_0:   val = 4'd0;
      SEG_1:   val = 4'd1;
      SEG_2:   val = 4'd2;
      SEG_3:   val = 4'd3;
      SEG_4:   val = 4'd4;
      SEG_5:   val = 4'd5;
      SEG_6:   val = 4'd6;
      SEG_7:   val = 4'd7;
      SEG_8:   val = 4'd8;
      SEG_9:   val = 4'd9;
      default: err_o = 1'b1;
    endcase
  end

  assign value_o = DIG_W'(val);
endmodule

// File: rtl/seg_frame_decoder.sv
// Collects N_DIGITS segment codes into one decoded frame and hands it off via valid/ready.
// Optional macro SEG_DEC_ERR_COUNT_EN enables the saturating unrecognised-code counter.
module seg_frame_decoder
  import seg_codes_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 8,
  parameter int DIG_W    = 4
) (
  input logic               clk,
  input logic               rst,
  seg_frame_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(N_DIGITS);

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          pos_d;
  logic                      seg_ready_q;
  logic                      frame_valid_q;
  logic [N_DIGITS*DIG_W-1:0] data_q;
  logic [N_DIGITS*DIG_W-1:0] data_d;
  logic [N_DIGITS-1:0]       err_q;
  logic [N_DIGITS-1:0]       err_d;
  logic [DIG_W-1:0]          dec_val;
  logic                      dec_err;
  logic                      accept;

  assign accept = bus.seg_valid & seg_ready_q;

  seg_pattern_decode #(
    .SEG_W(SEG_W),
    .DIG_W(DIG_W)
  ) u_decode (
    .seg_code_i(bus.seg_code),
    .value_o   (dec_val),
    .err_o     (dec_err)
  );

  // frame_start restarts at digit 0 and drops the error flags of the abandoned partial frame
  always_comb begin
    pos_d  = bus.frame_start ? '0 : idx_q;
    data_d = data_q;
    err_d  = bus.frame_start ? '0 : err_q;
    data_d[pos_d*DIG_W +: DIG_W] = dec_val;
    err_d[pos_d]                 = dec_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      seg_ready_q   <= 1'b1;
      frame_valid_q <= 1'b0;
      data_q        <= '0;
      err_q         <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            data_q <= data_d;
            err_q  <= err_d;
            idx_q  <= pos_d + 1'b1;
            if (pos_d == IDX_W'(N_DIGITS - 1)) begin
              state_q       <= HOLD;
              seg_ready_q   <= 1'b0;
              frame_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.frame_ready) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            seg_ready_q   <= 1'b1;
            frame_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SEG_DEC_ERR_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && dec_err && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.err_count = cnt_q;
`else
  assign bus.err_count = '0;
`endif

  assign bus.seg_ready   = seg_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = data_q;
  assign bus.frame_err   = err_q;
endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder: array-based frame model checked every cycle,
// plus literal expectations for each scenario.
module tb_seg_frame_decoder;
  import seg_codes_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic load_cnt;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  seg_frame_decoder_if #(.N_DIGITS(N), .SEG_W(8), .DIG_W(4)) sif ();

  seg_frame_decoder #(.N_DIGITS(N), .SEG_W(8), .DIG_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  int          m_val [N];
  bit          m_err [N];
  int          m_idx;
  bit          m_hold;
  logic [15:0] m_cnt;

  function automatic void decode(input logic [7:0] c, output int v, output bit e);
    v = 15;
    e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (c[7:1] == tbl[i]) begin
        v = i;
        e = 1'b0;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    int v;
    bit e;
    int p;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_val[k] = 0;
        m_err[k] = 1'b0;
      end
      m_idx  = 0;
      m_hold = 1'b0;
      m_cnt  = 16'h0000;
    end else begin
      if (!m_hold && sif.seg_valid) begin
        p = sif.frame_start ? 0 : m_idx;
        if (sif.frame_start)
          for (int k = 0; k < N; k++) m_err[k] = 1'b0;
        decode(sif.seg_code, v, e);
        m_val[p] = v;
        m_err[p] = e;
        m_idx    = p + 1;
`ifdef SEG_DEC_ERR_COUNT_EN
        if (e && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        if (p == N - 1) m_hold = 1'b1;
      end else if (m_hold && sif.frame_ready) begin
        m_hold = 1'b0;
        m_idx  = 0;
      end
      if (load_cnt) m_cnt = 16'hFFFE;
    end
  end

  always @(negedge clk) begin
    logic [15:0] ed;
    logic [3:0]  ee;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        ed[k*4 +: 4] = 4'(m_val[k]);
        ee[k]        = m_err[k];
      end
      chk("seg_ready", 32'(sif.seg_ready), 32'(!m_hold));
      chk("frame_valid", 32'(sif.frame_valid), 32'(m_hold));
      if (m_hold) begin
        chk("frame_data", 32'(sif.frame_data), 32'(ed));
        chk("frame_err", 32'(sif.frame_err), 32'(ee));
      end
      if (!load_cnt) chk("err_count", 32'(sif.err_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] code, input logic start);
    sif.seg_valid   = 1'b1;
    sif.seg_code    = code;
    sif.frame_start = start;
    @(posedge clk);
    #1;
    sif.seg_valid   = 1'b0;
    sif.frame_start = 1'b0;
  endtask

  task automatic release_frame();
    sif.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    sif.frame_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    load_cnt        = 1'b0;
    sif.seg_valid   = 1'b0;
    sif.seg_code    = 8'h00;
    sif.frame_start = 1'b0;
    sif.frame_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(sif.seg_ready), 32'd1);
    chk("rst_valid", 32'(sif.frame_valid), 32'd0);
    chk("rst_data", 32'(sif.frame_data), 32'h0);
    chk("rst_err", 32'(sif.frame_err), 32'h0);
    chk("rst_cnt", 32'(sif.err_count), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: clean frame 0,1,2,3
    send(8'b11111100, 1'b0);
    send(8'b01100000, 1'b0);
    send(8'b11011010, 1'b0);
    chk("t1_not_yet", 32'(sif.frame_valid), 32'd0);
    send(8'b11110010, 1'b0);
    chk("t1_valid", 32'(sif.frame_valid), 32'd1);
    chk("t1_data", 32'(sif.frame_data), 32'h3210);
    chk("t1_err", 32'(sif.frame_err), 32'h0);
    chk("t1_ready", 32'(sif.seg_ready), 32'd0);

    // 2: hold with codes offered, then release
    sif.seg_valid = 1'b1;
    sif.seg_code  = 8'b11111100;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t2_hold_data", 32'(sif.frame_data), 32'h3210);
      chk("t2_hold_valid", 32'(sif.frame_valid), 32'd1);
    end
    sif.seg_valid = 1'b0;
    release_frame();
    chk("t2_valid_low", 32'(sif.frame_valid), 32'd0);
    chk("t2_ready_high", 32'(sif.seg_ready), 32'd1);

    // 3: one unrecognised digit
    send(8'b01100110, 1'b0);
    send(8'b00000001, 1'b0);
    send(8'b11100001, 1'b0);
    send(8'b10110110, 1'b0);
    chk("t3_data", 32'(sif.frame_data), 32'h57F4);
    chk("t3_err", 32'(sif.frame_err), 32'b0010);
`ifdef SEG_DEC_ERR_COUNT_EN
    chk("t3_cnt", 32'(sif.err_count), 32'd1);
`else
    chk("t3_cnt", 32'(sif.err_count), 32'd0);
`endif
    release_frame();

    // 4: frame_start discards a partial frame; frame_ready in COLLECT is ignored
    sif.frame_ready = 1'b1;
    send(8'b11111100, 1'b0);
    send(8'b00000001, 1'b0);
    sif.frame_ready = 1'b0;
    send(8'b11111110, 1'b1);
    send(8'b11110110, 1'b0);
    send(8'b11110110, 1'b0);
    chk("t4_not_yet", 32'(sif.frame_valid), 32'd0);
    send(8'b11110110, 1'b0);
    chk("t4_data", 32'(sif.frame_data), 32'h9998);
    chk("t4_err", 32'(sif.frame_err), 32'h0);
    release_frame();

    // 5: asynchronous reset mid-collect
    send(8'b01100000, 1'b0);
    send(8'b11011010, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("t5_ready", 32'(sif.seg_ready), 32'd1);
    chk("t5_valid", 32'(sif.frame_valid), 32'd0);
    chk("t5_data", 32'(sif.frame_data), 32'h0);
    chk("t5_cnt", 32'(sif.err_count), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'b10110110, 1'b0);
    send(8'b10111110, 1'b0);
    send(8'b11100000, 1'b0);
    send(8'b11111110, 1'b0);
    chk("t5_frame", 32'(sif.frame_data), 32'h8765);
    chk("t5_ferr", 32'(sif.frame_err), 32'h0);
    release_frame();

`ifdef SEG_DEC_ERR_COUNT_EN
    // 6: counter saturation
    force dut.cnt_q = 16'hFFFE;
    load_cnt = 1'b1;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    load_cnt = 1'b0;
    chk("t6_preload", 32'(sif.err_count), 32'hFFFE);
    send(SEG_ERR, 1'b0);
    chk("t6_first", 32'(sif.err_count), 32'hFFFF);
    send(8'b00000000, 1'b0);
    send(8'b10101010, 1'b0);
    chk("t6_sat", 32'(sif.err_count), 32'hFFFF);
`endif

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
